// File: rtl/rx_packet_arbiter.sv
// Per-port one-word RX holding registers. A round-robin arbiter drains them into a shared USB TX FIFO.
// Reset asserts asynchronously. Release takes effect at the next rising edge, so the first capture happens on that edge.
module rx_packet_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = 32,
  localparam int ADDR_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_full,
  input  logic [NUM_PORTS-1:0]            port_enable,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [ADDR_WIDTH-1:0]           out_addr,
  output logic                            out_wr_en,
  input  logic                            fifo_full,
  output logic [NUM_PORTS-1:0]            overflow,
  output logic                            idle
);

  logic [NUM_PORTS-1:0]  buf_valid;
  logic [DATA_WIDTH-1:0] buf_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]  overflow_q;
  logic [ADDR_WIDTH-1:0] last_grant;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_data;

  logic [NUM_PORTS-1:0]  elig;
  logic                  any_elig;
  logic                  found;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] win;

  // Round-robin search starting one past the last granted port
  always_comb begin
    elig     = buf_valid & port_enable;
    any_elig = |elig;
    found    = 1'b0;
    win      = last_grant;
    idx      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = ADDR_WIDTH'((int'(last_grant) + k) % NUM_PORTS);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign out_wr_en = any_elig & ~fifo_full;
  assign out_data  = any_elig ? buf_data[win] : hold_data;
  assign out_addr  = any_elig ? win : hold_addr;
  assign in_full   = buf_valid;
  assign overflow  = overflow_q;
  assign idle      = ~|buf_valid;

  // Capture stage: control state under reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid  <= '0;
      overflow_q <= '0;
      last_grant <= ADDR_WIDTH'(NUM_PORTS - 1);
      hold_addr  <= '0;
      hold_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (in_valid[i] && buf_valid[i]) overflow_q[i] <= 1'b1;
        if (out_wr_en && (win == ADDR_WIDTH'(i))) buf_valid[i] <= 1'b0;
        else if (in_valid[i] && !buf_valid[i]) buf_valid[i] <= 1'b1;
      end
      if (out_wr_en) last_grant <= win;
      if (any_elig) begin
        hold_addr <= win;
        hold_data <= buf_data[win];
      end
    end
  end

  // Holding registers carry data only; occupancy is tracked by buf_valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_valid[i] && !buf_valid[i]) buf_data[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_rx_packet_arbiter.sv
// Bench for rx_packet_arbiter: directed scenarios plus randomized traffic.
// Each step is checked against a per-port queue reference model.
module tb_rx_packet_arbiter;
  localparam int NP = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP*DW-1:0] in_data;
  logic [NP-1:0]   in_valid;
  logic [NP-1:0]   in_full;
  logic [NP-1:0]   port_enable;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_addr;
  logic            out_wr_en;
  logic            fifo_full;
  logic [NP-1:0]   overflow;
  logic            idle;

  rx_packet_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_full(in_full),
    .port_enable(port_enable), .out_data(out_data), .out_addr(out_addr),
    .out_wr_en(out_wr_en), .fifo_full(fifo_full), .overflow(overflow), .idle(idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered word per port, pending-word queues for ordering
  logic [NP-1:0] mvalid;
  logic [DW-1:0] mdata [NP];
  logic [NP-1:0] movf;
  int            mlast;
  logic [DW-1:0] mhold_d;
  int            mhold_a;
  logic [DW-1:0] sb [NP][$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    mvalid  = '0;
    movf    = '0;
    mlast   = NP - 1;
    mhold_d = '0;
    mhold_a = 0;
    for (int i = 0; i < NP; i++) sb[i].delete();
  endtask

  task automatic clear_inputs();
    in_valid  = '0;
    in_data   = '0;
    fifo_full = 1'b0;
  endtask

  task automatic set_word(input int p, input logic [DW-1:0] w);
    in_data[p*DW +: DW] = w;
    in_valid[p] = 1'b1;
  endtask

  // Check one cycle's outputs, advance through the rising edge, update the model
  task automatic step();
    int   win;
    bit   any;
    logic exp_wr;
    #1;
    any = 0;
    win = mlast;
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (mlast + k) % NP;
      if (!any && mvalid[p] && port_enable[p]) begin
        any = 1;
        win = p;
      end
    end
    exp_wr = any && !fifo_full;
    chk("out_wr_en", out_wr_en, exp_wr);
    chk("out_addr", out_addr, any ? win : mhold_a);
    chk("out_data", out_data, any ? mdata[win] : mhold_d);
    chk("in_full", in_full, mvalid);
    chk("overflow", overflow, movf);
    chk("idle", idle, mvalid == '0);
    if (exp_wr) begin
      if (sb[win].size() == 0) chk("order_nodup", 1, 0);
      else chk("order", out_data, sb[win].pop_front());
    end
    @(posedge clk);
    for (int i = 0; i < NP; i++) begin
      if (in_valid[i] && mvalid[i]) movf[i] = 1'b1;
      if (exp_wr && win == i) mvalid[i] = 1'b0;
      else if (in_valid[i] && !mvalid[i]) begin
        mvalid[i] = 1'b1;
        mdata[i]  = in_data[i*DW +: DW];
        sb[i].push_back(in_data[i*DW +: DW]);
      end
    end
    if (exp_wr) mlast = win;
    if (any) begin
      mhold_d = mdata[win];
      mhold_a = win;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    port_enable = '1;
    clear_inputs();
    mreset();
    #3;
    chk("rst_wr_en", out_wr_en, 0);
    chk("rst_in_full", in_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_idle", idle, 1);
    @(negedge clk);
    rst = 1'b1;

    // All four ports loaded together: grants 0..3, twice
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NP; p++) set_word(p, 32'h1000_0000 + r*16 + p);
      step();
      clear_inputs();
      for (int p = 0; p < NP; p++) begin
        #1;
        chk("rr_addr", out_addr, p);
        chk("rr_data", out_data, 32'h1000_0000 + r*16 + p);
        step();
      end
      #1;
      chk("rr_idle", idle, 1);
    end

    // Shared FIFO full with ports 1 and 3 loaded
    fifo_full = 1'b1;
    set_word(1, 32'hBEEF_0001);
    set_word(3, 32'hBEEF_0003);
    step();
    in_valid = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("ff_wr_en", out_wr_en, 0);
      chk("ff_full1", in_full[1], 1);
      chk("ff_full3", in_full[3], 1);
      step();
    end
    fifo_full = 1'b0;
    #1;
    chk("ff_grant1", out_addr, 1);
    step();
    #1;
    chk("ff_grant3", out_addr, 3);
    step();

    // Single word on port 2 appears the next cycle
    set_word(2, 32'hA5A5_A5A5);
    step();
    clear_inputs();
    #1;
    chk("single_wr_en", out_wr_en, 1);
    chk("single_addr", out_addr, 2);
    chk("single_data", out_data, 32'hA5A5_A5A5);
    step();
    #1;
    chk("single_idle", idle, 1);

    // Back-to-back words on port 0: second one is dropped
    set_word(0, 32'h1111_1111);
    step();
    set_word(0, 32'h2222_2222);
    #1;
    chk("ovf_first_data", out_data, 32'h1111_1111);
    chk("ovf_first_wr", out_wr_en, 1);
    step();
    clear_inputs();
    #1;
    chk("ovf_flag", overflow[0], 1);
    chk("ovf_idle", idle, 1);
    step();
    step();
    chk("ovf_sticky", overflow[0], 1);

    // Disabled port keeps its word until re-enabled
    port_enable = 4'b1101;
    set_word(1, 32'h0000_0111);
    set_word(2, 32'h0000_0222);
    step();
    clear_inputs();
    #1;
    chk("en_grant2", out_addr, 2);
    step();
    #1;
    chk("en_hold1", in_full[1], 1);
    chk("en_no_wr", out_wr_en, 0);
    port_enable = '1;
    #1;
    chk("en_grant1", out_addr, 1);
    chk("en_data1", out_data, 32'h0000_0111);
    step();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) in_data[p*DW +: DW] = $urandom;
      in_valid    = NP'($urandom_range(0, 15));
      port_enable = ($urandom_range(0, 3) == 0) ? NP'($urandom_range(0, 15)) : '1;
      fifo_full   = ($urandom_range(0, 3) == 0);
      step();
    end
    port_enable = '1;
    clear_inputs();
    for (int c = 0; c < 6; c++) step();

    // Reset asserted while ports 0 and 3 hold words
    fifo_full = 1'b1;
    set_word(0, 32'hCAFE_0000);
    set_word(3, 32'hCAFE_0003);
    step();
    clear_inputs();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_wr_en", out_wr_en, 0);
    chk("arst_idle", idle, 1);
    chk("arst_in_full", in_full, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_data", out_data, 0);
    mreset();
    @(negedge clk);
    step();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) step();
    chk("arst_no_output", out_wr_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
